// File: rtl/pc_unit_if.sv
// Control/status bundle between the control unit and the program-counter unit.
// The control unit (master) drives the operation request; the PC unit (slave)
// returns the program address and stack/fault status.
interface pc_unit_if #(
  parameter int AB    = 11,
  parameter int OFF_W = 8
);
  logic             en;
  logic [2:0]       op;
  logic [AB-1:0]    address_bus;
  logic [OFF_W-1:0] offset;
  logic             resume;
  logic [AB-1:0]    Addr;
  logic             halted;
  logic             stk_empty;
  logic             stk_full;
  logic             err;

  modport master (
    output en, op, address_bus, offset, resume,
    input  Addr, halted, stk_empty, stk_full, err
  );

  modport slave (
    input  en, op, address_bus, offset, resume,
    output Addr, halted, stk_empty, stk_full, err
  );
endinterface

// File: rtl/pc_unit.sv
// Program-counter unit: hold / increment / jump / relative branch /
// call-return through an internal return-address stack, plus a halt state.
// All outputs come straight from registers; nothing combinational from inputs.
module pc_unit #(
  parameter int AB          = 11,
  parameter int OFF_W       = 8,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_ADDR  = 0
) (
  input  logic     clk,
  input  logic     rst,
  pc_unit_if.slave bus
);

  localparam int CW = $clog2(STACK_DEPTH + 1);
  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_e;

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_INC  = 3'd1,
    OP_JMP  = 3'd2,
    OP_BR   = 3'd3,
    OP_CALL = 3'd4,
    OP_RET  = 3'd5,
    OP_HALT = 3'd6,
    OP_RSVD = 3'd7
  } op_e;

  state_e        state_q, state_d;
  op_e           op_w;
  logic [AB-1:0] addr_q, addr_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;
  logic          do_push;
  logic          full_w, empty_w;
  logic [AB-1:0] addr_inc;
  logic [AB-1:0] off_ext;
  logic [IW-1:0] push_idx, pop_idx;

  logic [AB-1:0] stack_mem [STACK_DEPTH];

  assign op_w     = op_e'(bus.op);
  assign addr_inc = addr_q + AB'(1);
  assign off_ext  = AB'($signed(bus.offset));
  assign empty_w  = (count_q == '0);
  assign full_w   = (count_q == CW'(STACK_DEPTH));
  assign push_idx = IW'(count_q);
  assign pop_idx  = IW'(count_q - CW'(1));

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_RUN;
    else     state_q <= state_d;
  end

  // FSM next state: HALT op enters HALT, resume leaves it; en gates both
  always_comb begin
    state_d = state_q;
    if (bus.en) begin
      unique case (state_q)
        S_RUN:  if (op_w == OP_HALT) state_d = S_HALT;
        S_HALT: if (bus.resume)      state_d = S_RUN;
        default: state_d = S_RUN;
      endcase
    end
  end

  // FSM/status outputs, all taken from registered state
  always_comb begin
    bus.halted    = (state_q == S_HALT);
    bus.Addr      = addr_q;
    bus.stk_empty = empty_w;
    bus.stk_full  = full_w;
    bus.err       = err_q;
  end

  // Datapath next values: op decode only while running and enabled
  always_comb begin
    addr_d  = addr_q;
    count_d = count_q;
    err_d   = err_q;
    do_push = 1'b0;
    if (bus.en && state_q == S_RUN) begin
      unique case (op_w)
        OP_INC: addr_d = addr_inc;
        OP_JMP: addr_d = bus.address_bus;
        OP_BR:  addr_d = addr_q + off_ext;
        OP_CALL: begin
          if (full_w) begin
            err_d = 1'b1;
          end else begin
            do_push = 1'b1;
            count_d = count_q + CW'(1);
            addr_d  = bus.address_bus;
          end
        end
        OP_RET: begin
          if (empty_w) begin
            err_d = 1'b1;
          end else begin
            addr_d  = stack_mem[pop_idx];
            count_d = count_q - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers: address, stack depth, sticky fault
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= AB'(RESET_ADDR);
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Return-address storage; contents need no reset since count governs validity
  always_ff @(posedge clk) begin
    if (!rst && do_push) stack_mem[push_idx] <= addr_inc;
  end

endmodule
